inst_queue_decoder_m: RTL

INST_QUEUE_DECODER_M -- requirements
Module: inst_queue_decoder_m

---
 rtl/inst_queue_decoder_m.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/inst_queue_decoder_m.sv
// X-Makina fetch queue: DEPTH-entry circular FIFO of {pc, inst} feeding a registered decode stage.
// Latency: push at edge N into an empty block is decoded after edge N+1; fetch_ready depends on queue fill only.
module inst_queue_decoder_m #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [15:0]              fetch_inst,
    input  logic [ADDR_W-1:0]        fetch_pc,
    input  logic                     flush,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [ADDR_W-1:0]        dec_pc,
    output logic [2:0]               operation,
    output logic                     byte_inst,
    output logic                     src_op_type,
    output logic [2:0]               src_op,
    output logic [2:0]               dst_op,
    output logic [3:0]               alu_func,
    output logic [2:0]               branch_cond,
    output logic [15:0]              imm_val,
    output logic [15:0]              addr_offset,
    output logic [15:0]              branch_offset,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [2:0]  operation;
        logic        byte_inst;
        logic        src_op_type;
        logic [2:0]  src_op;
        logic [2:0]  dst_op;
        logic [3:0]  alu_func;
        logic [2:0]  branch_cond;
        logic [15:0] imm_val;
        logic [15:0] addr_offset;
        logic [15:0] branch_offset;
        logic        illegal;
    } dec_t;

    logic [15:0]       r_mem_inst [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    dec_t              r_dec;
    logic [ADDR_W-1:0] r_dec_pc;
    logic              r_dec_vld;

    logic              w_push;
    logic              w_load;
    logic [15:0]       w_inst;
    dec_t              w_dec;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fetch_ready = (r_count < CW'(DEPTH));
    assign w_push      = fetch_valid && fetch_ready && !flush;
    assign w_load      = (r_count != '0) && (!r_dec_vld || dec_ready) && !flush;
    assign w_inst      = r_mem_inst[r_rptr];

    always_comb begin
        w_dec        = '0;
        w_dec.src_op = w_inst[5:3];
        w_dec.dst_op = w_inst[2:0];
        if (w_inst[15:13] == 3'b000) begin
            w_dec.operation     = 3'd0;
            w_dec.branch_offset = {{2{w_inst[12]}}, w_inst[12:0], 1'b0};
        end else if (w_inst[15:13] == 3'b001) begin
            w_dec.operation     = 3'd1;
            w_dec.branch_cond   = w_inst[12:10];
            w_dec.branch_offset = {{5{w_inst[9]}}, w_inst[9:0], 1'b0};
        end else if (w_inst[15:12] == 4'b0100) begin
            w_dec.operation   = 3'd2;
            w_dec.alu_func    = w_inst[11:8];
            w_dec.src_op_type = w_inst[7];
            w_dec.byte_inst   = w_inst[6];
        end else if (w_inst[15:12] == 4'b0101) begin
            w_dec.operation = 3'd3;
            w_dec.byte_inst = w_inst[6];
        end else if (w_inst[15:13] == 3'b011) begin
            w_dec.operation = 3'd7;
            w_dec.imm_val   = {(w_inst[12:11] == 2'b10) ? 8'hFF : 8'h00, w_inst[10:3]};
            w_dec.illegal   = (w_inst[12:11] == 2'b11);
        end else if (w_inst[15:14] == 2'b10) begin
            w_dec.operation   = 3'd5;
            w_dec.addr_offset = {{9{w_inst[13]}}, w_inst[13:7]};
        end else begin
            w_dec.operation   = 3'd4;
            w_dec.addr_offset = {{9{w_inst[13]}}, w_inst[13:7]};
        end
    end

    // Storage carries no reset: occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wptr] <= fetch_inst;
            r_mem_pc[r_wptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_load) r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dec     <= '0;
            r_dec_pc  <= '0;
            r_dec_vld <= 1'b0;
        end else if (flush) begin
            r_dec_vld <= 1'b0;
        end else if (w_load) begin
            r_dec     <= w_dec;
            r_dec_pc  <= r_mem_pc[r_rptr];
            r_dec_vld <= 1'b1;
        end else if (r_dec_vld && dec_ready) begin
            r_dec_vld <= 1'b0;
        end
    end

    assign count         = r_count;
    assign dec_valid     = r_dec_vld;
    assign dec_pc        = r_dec_pc;
    assign operation     = r_dec.operation;
    assign byte_inst     = r_dec.byte_inst;
    assign src_op_type   = r_dec.src_op_type;
    assign src_op        = r_dec.src_op;
    assign dst_op        = r_dec.dst_op;
    assign alu_func      = r_dec.alu_func;
    assign branch_cond   = r_dec.branch_cond;
    assign imm_val       = r_dec.imm_val;
    assign addr_offset   = r_dec.addr_offset;
    assign branch_offset = r_dec.branch_offset;
    assign illegal       = r_dec.illegal;

endmodule
